axi_logpwr_avg: RTL
===================

Name: axi_logpwr_avg

Overview:
Per-bin averager that consumes the 16-bit unsigned log-power stream emitted by axi_logpwr.
- Input is a series of frames (FFT vectors) delimited by i_tlast.
- Keeps a per-bin exponential (IIR) average in block RAM across frames.
- Emits one averaged frame every `decim` input frames, toward the AXI wrapper's s_axis path.

Parameters:
MAX_LEN_LOG2, 11, log2 of maximum frame length in bins (RAM depth 2^MAX_LEN_LOG2).
WIDTH, 16, sample width of input and output.

Ports:
clk  in  1  single clock, all logic synchronous to it.
reset  in  1  synchronous, active-high.
clear  in  1  single-cycle pulse; discards average history.
alpha_shift  in  4  IIR weight 2^-alpha_shift; 0 = pass-through.
decim  in  8  output one frame per decim frames; 0 treated as 1.
i_tdata  in  WIDTH  unsigned log-power bin.
i_tlast  in  1  last bin of frame.
i_tvalid  in  1  input valid.
i_tready  out  1  input ready.
o_tdata  out  WIDTH  averaged bin, unsigned.
o_tlast  out  1  last bin of emitted frame.
o_tvalid  out  1  output valid.
o_tready  in  1  output ready.
len_err  out  1  one-cycle pulse on frame-length mismatch.

Behaviour:
Interface:
- One clock `clk`; reset `reset` is synchronous, active-high.
- Reset values: o_tvalid=0, o_tlast=0, o_tdata=0, len_err=0, state=SEED, bin index=0, frame counter=0.
- i_tready is 0 during reset and in the cycle after reset deasserts.

Accumulator:
- Width ACC=WIDTH+8 (8 fractional bits).
- SEED: acc = x<<8.
- AVG: acc = acc + ((x<<8) - acc) >>> alpha_shift. The difference is signed ACC+1 bits; the result is never negative and never exceeds 0xFFFF<<8.
- Output = (acc + 128) >> 8, saturated to 2^WIDTH-1.

Pipeline:
- Stage 0: accept; RAM read at bin index.
- Stage 1: update; RAM write-back.
- Output register follows stage 1.
- Latency from accepted input to o_tvalid is 2 cycles.
- The whole pipeline advances when (!o_tvalid || o_tready); i_tready = advance. Full throughput at 1 bin/cycle.
- Bypass: a read of the address written in the same or previous cycle (frame length 1 or 2) uses the forwarded value, never stale RAM.

FSM:
- SEED: first frame after reset/clear/error. Writes seeded values. Bin count at the accepted tlast latches frame length L. Goes to AVG on tlast.
- AVG: stays in AVG while frames match L.
- Length error, either case:
  - tlast at index != L-1, or
  - index reaches L-1 without tlast.
- On length error: pulse len_err, go to SEED. The current sample is treated as bin 0 of a new seed frame when the index overflowed; a short tlast ends the frame and the next frame seeds.
- A seed frame longer than 2^MAX_LEN_LOG2: index wraps to 0, len_err pulses, and the block remains in SEED.

Decimation:
- decim is latched at frame start.
- Frame counter increments on each accepted tlast and wraps at decim_eff-1.
- Only bins of frames where counter == decim_eff-1 produce output; other bins are consumed without output.
- The seed frame counts as a frame.

clear:
- Takes effect the next cycle: state=SEED, index=0, counter=0.
- Pipeline contents already accepted still drain to the output.
- Remaining bins of an interrupted frame start a new seed frame.
- clear and reset are equivalent except that in-flight output is preserved.

Optional Feature:
AXI_LOGPWR_AVG_PEAK_HOLD_EN
- Defined: adds input port peak_mode (1 bit, latched at frame start). When high, the AVG update is acc = max(acc, x<<8) and alpha_shift is ignored.
- Undefined: the port is absent and only IIR averaging exists.

Decomposition:
- Package axi_logpwr_avg_pkg holds:
  - FRAC_BITS=8
  - ACC_WIDTH function of WIDTH
  - state enum {SEED, AVG}
  - rounding/saturation function
- One sub-module, axi_logpwr_avg_ram: simple dual-port RAM, 2^MAX_LEN_LOG2 x ACC_WIDTH, 1-cycle read latency, read-first.

Test Plan:
- alpha_shift=1, decim=1, L=4; frame of 100s then frame of 200s -> second output frame all 150, o_tlast on 4th bin.
- alpha_shift=0, decim=3, six frames of values 10..15 -> exactly two output frames, equal to frames 3 and 6; no output for others.
- L=1 frames (tlast every beat), alpha_shift=2, inputs 0,400,400 -> outputs 0,100,175; verifies the bypass path.
- Seed L=8, then frame with tlast at bin 5 -> len_err pulse at that beat; next 8-bin frame re-seeds and outputs raw input.
- Random o_tready (50% duty) over 1000 bins -> no drops or duplicates; order preserved; o_tdata stable while o_tvalid && !o_tready.
- clear asserted mid-frame after bin 2 of 8 -> bins 0-2 still output; subsequent bins seed; reset mid-frame -> o_tvalid=0 next cycle.

Source files
------------

// File: rtl/axi_logpwr_avg_pkg.sv
// Shared definitions for the per-bin log-power averager.
//   FRAC_BITS  : fractional bits carried by the accumulator
//   acc_width  : accumulator width for a given sample width
//   state_t    : frame-tracking FSM states
//   round_sat  : accumulator -> output sample (round half up, saturate)
package axi_logpwr_avg_pkg;

   localparam int FRAC_BITS = 8;

   typedef enum logic {
      ST_SEED = 1'b0,
      ST_AVG  = 1'b1
   } state_t;

   function automatic int acc_width(input int width);
      return width + FRAC_BITS;
   endfunction

   // Accumulator must be narrower than 32 bits so acc+half cannot overflow.
   function automatic logic [31:0] round_sat(input logic [31:0] acc, input int unsigned width);
      logic [31:0] r;
      logic [31:0] lim;
      r   = (acc + 32'd128) >> FRAC_BITS;
      lim = (32'd1 << width) - 32'd1;
      if (r > lim) r = lim;
      return r;
   endfunction

endpackage

// File: rtl/axi_logpwr_avg_if.sv
// AXI-stream style bundle used for both the sample input and averaged output.
//   tdata  : sample (WIDTH bits, unsigned)
//   tlast  : last bin of a frame
//   tvalid : producer has a sample
//   tready : consumer takes the sample
interface axi_logpwr_avg_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] tdata;
   logic             tlast;
   logic             tvalid;
   logic             tready;

   modport master (output tdata, output tlast, output tvalid, input tready);
   modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axi_logpwr_avg_ram.sv
// Simple dual-port accumulator RAM, one write port and one read port,
// 1-cycle read latency, read-first on a same-address collision.
//   i_we/i_waddr/i_wdata : write port
//   i_re/i_raddr         : read port; o_rdata holds while i_re is low
module axi_logpwr_avg_ram
   import axi_logpwr_avg_pkg::*;
#(
   parameter int AW = 11,
   parameter int DW = 24
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [0:(1<<AW)-1];
   logic [DW-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_logpwr_avg.sv
// Per-bin exponential averager for a framed 16-bit log-power stream.
// Keeps one accumulator per bin in RAM and emits one averaged frame every
// decim input frames.
//   clk, reset        : clock, synchronous active-high reset
//   clear             : one-cycle pulse, drops average history (in-flight output drains)
//   alpha_shift       : IIR weight 2^-alpha_shift (0 = pass-through)
//   decim             : output one frame per decim frames (0 acts as 1)
//   i_axis (slave)    : input bins, frames delimited by tlast
//   o_axis (master)   : averaged bins
//   len_err           : one-cycle pulse on frame-length mismatch
//   peak_mode         : only with AXI_LOGPWR_AVG_PEAK_HOLD_EN; latched at frame
//                       start, selects max-hold instead of IIR averaging
//
// state | meaning
// SEED  | first frame after reset/clear/error; writes x<<8, learns length L on tlast
// AVG   | frames of length L update accumulators; mismatch -> len_err, back to SEED
module axi_logpwr_avg
   import axi_logpwr_avg_pkg::*;
#(
   parameter int MAX_LEN_LOG2 = 11,
   parameter int WIDTH        = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic [3:0]  alpha_shift,
   input  logic [7:0]  decim,
`ifdef AXI_LOGPWR_AVG_PEAK_HOLD_EN
   input  logic        peak_mode,
`endif
   axi_logpwr_avg_if.slave  i_axis,
   axi_logpwr_avg_if.master o_axis,
   output logic        len_err
);

   localparam int            ACC      = acc_width(WIDTH);
   localparam int            AW       = MAX_LEN_LOG2;
   localparam logic [AW-1:0] IDX_MAX  = '1;
   localparam logic [AW-1:0] IDX_ONE  = 1;

   state_t          r_state, w_state_nxt;
   logic [AW-1:0]   r_idx, w_idx_nxt;
   logic [AW-1:0]   r_len_m1, w_len_m1_nxt;
   logic [7:0]      r_cnt, w_cnt_nxt;
   logic [7:0]      r_decim_lat, w_decim_cur, w_decim_in;
   logic            r_peak_lat, w_peak_cur, w_peak_in;
   logic            w_frame_start, w_err, w_seed, w_emit;
   logic [AW-1:0]   w_addr;

   logic            r_rdy_en;
   logic            w_advance, w_in_fire;

   logic            r_s1_valid, r_s1_seed, r_s1_emit, r_s1_last, r_s1_peak;
   logic [WIDTH-1:0] r_s1_x;
   logic [AW-1:0]   r_s1_addr;
   logic [3:0]      r_s1_shift;
   logic            r_fwd_hit;
   logic [ACC-1:0]  r_fwd_acc;

   logic [ACC-1:0]  w_ram_rdata, w_acc_old, w_x_acc, w_acc_iir, w_acc_new;
   logic signed [ACC:0] w_old_ext, w_diff, w_step;
   logic [WIDTH-1:0] w_out;

   logic            r_o_valid, r_o_last, r_len_err;
   logic [WIDTH-1:0] r_o_data;

`ifdef AXI_LOGPWR_AVG_PEAK_HOLD_EN
   assign w_peak_in = peak_mode;
`else
   assign w_peak_in = 1'b0;
`endif

   // Whole pipeline moves together; input is held off for one cycle after reset.
   assign w_advance     = !r_o_valid || o_axis.tready;
   assign i_axis.tready = w_advance && r_rdy_en && !reset;
   assign w_in_fire     = i_axis.tvalid && i_axis.tready;
   assign w_decim_in    = (decim == 8'd0) ? 8'd1 : decim;

   always_comb begin
      w_state_nxt   = r_state;
      w_idx_nxt     = r_idx;
      w_len_m1_nxt  = r_len_m1;
      w_cnt_nxt     = r_cnt;
      w_err         = 1'b0;
      w_seed        = (r_state == ST_SEED);
      w_addr        = r_idx;
      w_frame_start = (r_idx == '0);
      if (w_in_fire) begin
         if (r_state == ST_SEED) begin
            if (i_axis.tlast) begin
               w_len_m1_nxt = r_idx;
               w_state_nxt  = ST_AVG;
               w_idx_nxt    = '0;
            end else begin
               // Seed frame longer than the RAM: wrap and keep seeding.
               w_idx_nxt = r_idx + IDX_ONE;
               w_err     = (r_idx == IDX_MAX);
            end
         end else if (i_axis.tlast) begin
            w_idx_nxt = '0;
            if (r_idx != r_len_m1) begin
               w_err       = 1'b1;
               w_state_nxt = ST_SEED;
            end
         end else if (r_idx == r_len_m1) begin
            // Frame ran past L: this sample opens a new seed frame as bin 0.
            w_err         = 1'b1;
            w_state_nxt   = ST_SEED;
            w_seed        = 1'b1;
            w_addr        = '0;
            w_idx_nxt     = IDX_ONE;
            w_frame_start = 1'b1;
         end else begin
            w_idx_nxt = r_idx + IDX_ONE;
         end
      end
      w_decim_cur = w_frame_start ? w_decim_in : r_decim_lat;
      w_peak_cur  = w_frame_start ? w_peak_in  : r_peak_lat;
      w_emit      = (r_cnt >= (w_decim_cur - 8'd1));
      if (w_in_fire && i_axis.tlast) begin
         w_cnt_nxt = w_emit ? 8'd0 : (r_cnt + 8'd1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         r_state <= ST_SEED;
         r_idx   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_len_m1    <= '0;
         r_decim_lat <= 8'd1;
         r_peak_lat  <= 1'b0;
         r_rdy_en    <= 1'b0;
         r_len_err   <= 1'b0;
      end else begin
         r_rdy_en  <= 1'b1;
         r_len_err <= w_in_fire && w_err;
         if (w_in_fire) begin
            r_len_m1    <= w_len_m1_nxt;
            r_decim_lat <= w_decim_cur;
            r_peak_lat  <= w_peak_cur;
         end
      end
   end

   axi_logpwr_avg_ram #(.AW(AW), .DW(ACC)) u_ram (
      .clk     (clk),
      .i_we    (w_advance && r_s1_valid),
      .i_waddr (r_s1_addr),
      .i_wdata (w_acc_new),
      .i_re    (w_in_fire),
      .i_raddr (w_addr),
      .o_rdata (w_ram_rdata)
   );

   // Stage 1: the RAM is read-first, so a bin written on the same edge it is
   // read comes from the forward register instead.
   assign w_acc_old = r_fwd_hit ? r_fwd_acc : w_ram_rdata;
   assign w_x_acc   = {r_s1_x, {FRAC_BITS{1'b0}}};
   assign w_old_ext = $signed({1'b0, w_acc_old});
   assign w_diff    = $signed({1'b0, w_x_acc}) - w_old_ext;
   assign w_step    = w_diff >>> r_s1_shift;
   assign w_acc_iir = ACC'(w_old_ext + w_step);

   always_comb begin
      w_acc_new = w_acc_iir;
      if (r_s1_seed)      w_acc_new = w_x_acc;
      else if (r_s1_peak) w_acc_new = (w_x_acc > w_acc_old) ? w_x_acc : w_acc_old;
   end

   assign w_out = WIDTH'(round_sat(32'(w_acc_new), WIDTH));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1_valid <= 1'b0;
         r_fwd_hit  <= 1'b0;
      end else if (w_advance) begin
         r_s1_valid <= w_in_fire;
         if (w_in_fire) begin
            r_fwd_hit <= r_s1_valid && (r_s1_addr == w_addr);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_in_fire) begin
         r_s1_x     <= i_axis.tdata;
         r_s1_last  <= i_axis.tlast;
         r_s1_addr  <= w_addr;
         r_s1_seed  <= w_seed;
         r_s1_emit  <= w_emit;
         r_s1_shift <= alpha_shift;
         r_s1_peak  <= w_peak_cur;
         r_fwd_acc  <= w_acc_new;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_o_valid <= 1'b0;
         r_o_last  <= 1'b0;
         r_o_data  <= '0;
      end else if (w_advance) begin
         r_o_valid <= r_s1_valid && r_s1_emit;
         if (r_s1_valid && r_s1_emit) begin
            r_o_data <= w_out;
            r_o_last <= r_s1_last;
         end
      end
   end

   assign o_axis.tdata  = r_o_data;
   assign o_axis.tlast  = r_o_last;
   assign o_axis.tvalid = r_o_valid;
   assign len_err       = r_len_err;

endmodule
